// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode encodings,
// sequencer phase numbers and the ALU-opcode classifier.
package cpu_pkg;

  // Opcode encodings (3-bit opcode field of the instruction word)
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Sequencer phases, one instruction per full 0..7 sweep
  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // Opcodes that read an operand from data memory into the accumulator path
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase sequencer and control decoder for the accumulator CPU.
// The opcode is latched when leaving IDLE because the instruction memory
// output follows PC once the PC increments in OP_ADDR.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int PHASE_W = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               Zero,
  output logic               Sel,
  output logic               Rd,
  output logic               Ld_ir,
  output logic               Inc_pc,
  output logic               Ld_pc,
  output logic               Ld_ac,
  output logic               Data_e,
  output logic               Wr,
  output logic               Halt,
  output logic [PHASE_W-1:0] Phase
);

  logic [PHASE_W-1:0] r_phase;
  logic [OP_W-1:0]    r_op;
  logic               r_zero;
  logic               r_halt;
  logic               w_adv;
  logic               w_alu;
  logic               w_sto;
  logic               w_jmp;
  logic               w_skz;
  logic               w_hlt;

  assign w_adv  = Enable && !r_halt;
  assign w_alu  = is_aluop(r_op);
  assign w_sto  = (r_op == OP_STO);
  assign w_jmp  = (r_op == OP_JMP);
  assign w_skz  = (r_op == OP_SKZ);
  assign w_hlt  = (r_op == OP_HLT);
  assign Halt   = r_halt;
  assign Phase  = r_phase;

  // Phase counter plus opcode, zero-flag and halt capture on their phase exits
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_phase <= '0;
      r_op    <= '0;
      r_zero  <= 1'b0;
      r_halt  <= 1'b0;
    end else if (w_adv) begin
      r_phase <= r_phase + 1'b1;
      if (r_phase == PH_IDLE)
        r_op <= Opcode;
      if (r_phase == PH_ALU_OP)
        r_zero <= Zero;
      if ((r_phase == PH_OP_ADDR) && w_hlt)
        r_halt <= 1'b1;
    end
  end

  // Strobe decode from phase and latched opcode; halt forces every strobe low
  always_comb begin
    Sel    = 1'b0;
    Rd     = 1'b0;
    Ld_ir  = 1'b0;
    Inc_pc = 1'b0;
    Ld_pc  = 1'b0;
    Ld_ac  = 1'b0;
    Data_e = 1'b0;
    Wr     = 1'b0;
    case (r_phase)
      PH_INST_ADDR: begin
        Sel = 1'b1;
      end
      PH_INST_FETCH: begin
        Sel = 1'b1;
        Rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        Sel   = 1'b1;
        Rd    = 1'b1;
        Ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        Inc_pc = !w_hlt;
      end
      PH_OP_FETCH: begin
        Rd = w_alu;
      end
      PH_ALU_OP: begin
        Rd     = w_alu;
        Data_e = w_sto;
        Ld_pc  = w_jmp;
      end
      PH_STORE: begin
        Rd     = w_alu;
        Ld_ac  = w_alu;
        Wr     = w_sto;
        Data_e = w_sto;
        Ld_pc  = w_jmp;
        Inc_pc = w_skz && r_zero;
      end
      default: begin
        Sel = 1'b0;
      end
    endcase
    if (r_halt) begin
      Sel    = 1'b0;
      Rd     = 1'b0;
      Ld_ir  = 1'b0;
      Inc_pc = 1'b0;
      Ld_pc  = 1'b0;
      Ld_ac  = 1'b0;
      Data_e = 1'b0;
      Wr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-phase strobe vectors for each
// instruction class, enable hold, halt stickiness and asynchronous reset.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [2:0] Opcode;
  logic       Zero;
  logic       Sel, Rd, Ld_ir, Inc_pc, Ld_pc, Ld_ac, Data_e, Wr, Halt;
  logic [2:0] Phase;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_controller #(.OP_W(3), .PHASE_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Opcode(Opcode), .Zero(Zero),
    .Sel(Sel), .Rd(Rd), .Ld_ir(Ld_ir), .Inc_pc(Inc_pc), .Ld_pc(Ld_pc),
    .Ld_ac(Ld_ac), .Data_e(Data_e), .Wr(Wr), .Halt(Halt), .Phase(Phase)
  );

  always #5 Clk = ~Clk;

  // Strobe byte order: {Sel, Rd, Ld_ir, Inc_pc, Ld_pc, Ld_ac, Data_e, Wr}
  // Tables are {phase7, ..., phase0}, hand-derived from the phase table.
  localparam logic [63:0] EXP_LDA  = {8'h44, 8'h40, 8'h40, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80};
  localparam logic [63:0] EXP_STO  = {8'h03, 8'h02, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80};
  localparam logic [63:0] EXP_SKZ1 = {8'h10, 8'h00, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80};
  localparam logic [63:0] EXP_SKZ0 = {8'h00, 8'h00, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80};
  localparam logic [63:0] EXP_JMP  = {8'h08, 8'h08, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80};

  function automatic logic [7:0] strobes();
    return {Sel, Rd, Ld_ir, Inc_pc, Ld_pc, Ld_ac, Data_e, Wr};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs phases 0..stop_at-1 starting at a falling edge in phase 0. The real
  // opcode is presented only in IDLE, other phases carry junk; Zero is z only
  // in ALU_OP and inverted elsewhere.
  task automatic run_instr(input string name, input logic [2:0] op, input logic [2:0] junk,
                           input logic z, input logic [63:0] exp, input int stop_at);
    logic [63:0] tbl;
    tbl = exp;
    for (int p = 0; p < stop_at; p++) begin
      Opcode = (p == 3) ? op : junk;
      Zero   = (p == 6) ? z : ~z;
      check($sformatf("%s ph%0d phase", name, p), 32'(Phase), 32'(p));
      check($sformatf("%s ph%0d strobes", name, p), {23'd0, Halt, strobes()}, {24'd0, tbl[p*8 +: 8]});
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset  = 1'b1;
    Enable = 1'b0;
    Opcode = 3'b000;
    Zero   = 1'b0;
    @(negedge Clk);
    check("reset phase", 32'(Phase), 32'd0);
    check("reset strobes", {23'd0, Halt, strobes()}, 32'h80);
    Reset  = 1'b0;
    Enable = 1'b1;

    run_instr("LDA",  OP_LDA, 3'b010, 1'b0, EXP_LDA,  8);
    run_instr("STO",  OP_STO, 3'b001, 1'b0, EXP_STO,  8);
    run_instr("SKZ1", OP_SKZ, 3'b110, 1'b1, EXP_SKZ1, 8);
    run_instr("SKZ0", OP_SKZ, 3'b110, 1'b0, EXP_SKZ0, 8);
    run_instr("JMP",  OP_JMP, 3'b010, 1'b0, EXP_JMP,  8);
    run_instr("ADD",  OP_ADD, 3'b111, 1'b0, EXP_LDA,  8);

    // HLT with an enable hold inside INST_LOAD
    run_instr("HLT", OP_HLT, 3'b101, 1'b0, EXP_SKZ0, 2);
    check("hold entry phase", 32'(Phase), 32'd2);
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check($sformatf("hold%0d phase", i), 32'(Phase), 32'd2);
      check($sformatf("hold%0d ld_ir", i), 32'(Ld_ir), 32'd1);
    end
    Enable = 1'b1;
    @(negedge Clk);
    Opcode = OP_HLT;
    check("HLT ph3 phase", 32'(Phase), 32'd3);
    check("HLT ph3 strobes", {23'd0, Halt, strobes()}, 32'hE0);
    @(negedge Clk);
    Opcode = OP_LDA;
    check("HLT ph4 phase", 32'(Phase), 32'd4);
    check("HLT ph4 strobes", {23'd0, Halt, strobes()}, 32'h000);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check($sformatf("halted%0d phase", i), 32'(Phase), 32'd5);
      check($sformatf("halted%0d strobes", i), {23'd0, Halt, strobes()}, 32'h100);
    end

    // Reset clears halt; then an async reset in ALU_OP of a store
    #2 Reset = 1'b1;
    #1 check("halt reset phase", 32'(Phase), 32'd0);
    check("halt reset strobes", {23'd0, Halt, strobes()}, 32'h80);
    @(negedge Clk);
    Reset = 1'b0;
    run_instr("STOr", OP_STO, 3'b000, 1'b0, EXP_STO, 6);
    check("STOr ph6 phase", 32'(Phase), 32'd6);
    check("STOr ph6 strobes", {23'd0, Halt, strobes()}, 32'h02);
    #2 Reset = 1'b1;
    #1 check("async reset phase", 32'(Phase), 32'd0);
    check("async reset sel", 32'(Sel), 32'd1);
    check("async reset wr", 32'(Wr), 32'd0);
    check("async reset data_e", 32'(Data_e), 32'd0);
    check("async reset strobes", {23'd0, Halt, strobes()}, 32'h80);
    @(negedge Clk);
    Reset = 1'b0;
    run_instr("LDAr", OP_LDA, 3'b110, 1'b0, EXP_LDA, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
